// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

  // Default instruction memory depth in 32-bit words.
  localparam int INSTR_NUM  = 256;
  // Byte/word conversion.
  localparam int WORD_BYTES = 4;
  localparam int WORD_SHIFT = 2;

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } fetch_state_e;

  // One prefetched instruction together with the byte PC it came from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Force a byte address onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding prefetched {pc, instr} entries; flush beats push/pop.
// Latency: a push is visible at head_o the cycle after it is written.
// Backpressure: none internally; pushes into a full FIFO without a pop are dropped.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  fetch_entry_t  push_dat_i,
  input  logic          pop_i,
  output logic [CW-1:0] count_o,
  output fetch_entry_t  head_o
);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  fetch_entry_t  mem_q [DEPTH];
  logic          do_push;
  logic          do_pop;

  // Qualify push/pop against occupancy and compute next pointers/count.
  always_comb begin
    do_pop   = pop_i && (count_q != '0);
    do_push  = push_i && ((count_q != CW'(DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (do_push && !do_pop) count_d = count_q + CW'(1);
      if (do_pop && !do_push) count_d = count_q - CW'(1);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful while counted, so no reset.
  always_ff @(posedge clk_i) begin
    if (!flush_i && do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch_queue.sv
// Sequential instruction fetch with prefetch queue; FETCH_BOUNDS_CHECK_EN halts on out-of-range PC.
// Latency: request to instr_valid_o is 2 cycles; redirect to target valid is 3 cycles.
// Backpressure: instr_ready_i low fills the queue, then requests stop until space frees.
module instr_fetch_queue #(
  parameter int INSTR_NUM   = fetch_pkg::INSTR_NUM,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_data_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i,
  output logic        fetch_fault_o
);
  import fetch_pkg::*;

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   inflight_pc_q, inflight_pc_d;
  logic          kill_q, kill_d;

  logic [CW-1:0] fifo_count;
  fetch_entry_t  fifo_head;
  fetch_entry_t  push_dat;
  logic [CW-1:0] occ;
  logic          want;
  logic          in_range;
  logic          req;
  logic          push;
  logic          pop;
  logic [29:0]   mem_idx;

  // Request decision: room counts the word still in flight, redirect suppresses.
  always_comb begin
    occ = fifo_count + CW'(inflight_q);
`ifdef FETCH_BOUNDS_CHECK_EN
    in_range = fetch_pc_q[31:2] < 30'(INSTR_NUM);
    mem_idx  = fetch_pc_q[31:2];
`else
    in_range = 1'b1;
    mem_idx  = fetch_pc_q[31:2] % 30'(INSTR_NUM);
`endif
    want = rst_i && (state_q == FETCH) && (occ < CW'(QUEUE_DEPTH)) && !redirect_i;
    req  = want && in_range;
  end

  // FSM next state: redirect always returns to FETCH; an out-of-range fetch parks in HALT.
  always_comb begin
    state_d = state_q;
    if (redirect_i) begin
      state_d = FETCH;
    end
`ifdef FETCH_BOUNDS_CHECK_EN
    else if (want && !in_range) begin
      state_d = HALT;
    end
`endif
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (!rst_i) state_q <= FETCH;
    else        state_q <= state_d;
  end

  // Fetch PC, in-flight tracking and response kill; redirect wins over everything.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = req;
    inflight_pc_d = inflight_pc_q;
    kill_d        = 1'b0;
    if (redirect_i) begin
      fetch_pc_d = word_align(redirect_pc_i);
      kill_d     = inflight_q;
    end else if (req) begin
      fetch_pc_d    = fetch_pc_q + 32'(WORD_BYTES);
      inflight_pc_d = fetch_pc_q;
    end
  end

  // Fetch datapath registers.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      fetch_pc_q    <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      kill_q        <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      kill_q        <= kill_d;
    end
  end

  // Response capture and consumer handshake; flush priority lives in the FIFO.
  always_comb begin
    push           = inflight_q && !kill_q;
    push_dat.pc    = inflight_pc_q;
    push_dat.instr = imem_data_i;
    pop            = instr_valid_o && instr_ready_i;
  end

  fetch_fifo #(
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush_i    (redirect_i),
    .push_i     (push),
    .push_dat_i (push_dat),
    .pop_i      (pop),
    .count_o    (fifo_count),
    .head_o     (fifo_head)
  );

  assign imem_req_o    = req;
  assign imem_addr_o   = req ? (32'(mem_idx) << WORD_SHIFT) : '0;
  // Head fields are masked while empty so stale storage never shows.
  assign instr_valid_o = (fifo_count != '0);
  assign instr_o       = instr_valid_o ? fifo_head.instr : '0;
  assign instr_pc_o    = instr_valid_o ? fifo_head.pc : '0;
`ifdef FETCH_BOUNDS_CHECK_EN
  assign fetch_fault_o = (state_q == HALT);
`else
  assign fetch_fault_o = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
module tb_instr_fetch_queue;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_data_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;
  logic        fetch_fault_o;

  always #5 clk_i = ~clk_i;

  instr_fetch_queue #(.INSTR_NUM(256), .QUEUE_DEPTH(4)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_data_i   (imem_data_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_ready_i (instr_ready_i),
    .fetch_fault_o (fetch_fault_o)
  );

  // Instruction memory: one-cycle read latency.
  logic [31:0] mem [256];
  initial imem_data_i = '0;
  always @(posedge clk_i) if (imem_req_o) imem_data_i <= mem[imem_addr_o[9:2]];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: words requested but not yet consumed since the last
  // flush, the next PC to fetch, and the next PC the consumer should see.
  int          outstanding;
  bit          last_req;
  bit          halted;
  logic [31:0] mf;
  logic [31:0] exp_pc;
  bit          after_rst;
  int          cyc;
  int          first_vld_cyc = -1;
  bit          redir_pending;
  int          redir_cyc;
  int          redir_lat;
  bit          want_first;
  logic [31:0] first_pop;
  logic [31:0] last_pop_pc;
  bit          saw_wrap;
  bit          saw_pc400;

  task automatic step(input logic rst, input logic rdy, input logic redir, input logic [31:0] rpc);
    bit          exp_valid;
    bit          want;
    bit          oob;
    bit          exp_req;
    logic [31:0] exp_addr;
    rst_i         = rst;
    instr_ready_i = rdy;
    redirect_i    = redir;
    redirect_pc_i = rpc;
    #1;
    if (after_rst) begin
      chk("rst_valid", instr_valid_o, 0);
      chk("rst_instr", instr_o, 0);
      chk("rst_pc", instr_pc_o, 0);
      chk("rst_fault", fetch_fault_o, 0);
    end
    if (!rst) begin
      chk("rst_req", imem_req_o, 0);
      chk("rst_addr", imem_addr_o, 0);
      outstanding = 0; last_req = 0; halted = 0;
      mf = 0; exp_pc = 0; after_rst = 1; cyc = 0;
      redir_pending = 0; want_first = 0;
    end else begin
      after_rst = 0;
      cyc++;
      exp_valid = (outstanding - int'(last_req)) > 0;
      chk("valid", instr_valid_o, exp_valid);
      chk("fault", fetch_fault_o, halted);
      if (instr_valid_o && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (instr_valid_o && redir_pending) begin
        redir_lat = cyc - redir_cyc;
        redir_pending = 0;
      end
      want = !redir && !halted && (outstanding < 4);
`ifdef FETCH_BOUNDS_CHECK_EN
      oob = (mf / 4) >= 256;
`else
      oob = 0;
`endif
      exp_req = want && !oob;
      chk("req", imem_req_o, exp_req);
      if (exp_req && imem_req_o) begin
        exp_addr = ((mf / 4) % 256) * 4;
        chk("addr", imem_addr_o, exp_addr);
        if (mf == 32'h400 && imem_addr_o == 0) saw_wrap = 1;
      end
      if (exp_valid && rdy && !redir) begin
        chk("out_pc", instr_pc_o, exp_pc);
        chk("out_instr", instr_o, mem[exp_pc[9:2]]);
        last_pop_pc = instr_pc_o;
        if (instr_pc_o == 32'h400) saw_pc400 = 1;
        if (want_first) begin
          first_pop = instr_pc_o;
          want_first = 0;
        end
        exp_pc += 4;
        outstanding--;
      end
      if (redir) begin
        outstanding = 0; last_req = 0; halted = 0;
        mf = rpc & 32'hFFFF_FFFC; exp_pc = mf;
        redir_pending = 1; redir_cyc = cyc; want_first = 1;
      end else begin
        if (exp_req) begin
          outstanding++;
          mf += 4;
        end
        if (want && oob) halted = 1;
        last_req = exp_req;
      end
    end
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  initial begin
    logic [31:0] rpc;
    bit rdy, rd;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h20010005; mem[1] = 32'h20020003;
    mem[2] = 32'h00221820; mem[3] = 32'hAC030000;
    rst_i = 0; instr_ready_i = 0; redirect_i = 0; redirect_pc_i = 0;
    @(negedge clk_i);

    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 1, 0, 0);
    chk("first_vld_cyc", first_vld_cyc, 3);

    // Stall until the queue saturates, then drain in order.
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0);
    chk("stall_req_off", imem_req_o, 0);
    for (int i = 0; i < 8; i++) step(1, 1, 0, 0);

    // Redirect with a full queue and a word in flight.
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 1, 32'h40);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
    chk("redir_lat", redir_lat, 3);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0);
    chk("redir_first_pc", first_pop, 32'h40);

    // Unaligned redirect target.
    step(1, 1, 1, 32'h23);
    for (int i = 0; i < 6; i++) step(1, 1, 0, 0);
    chk("unaligned_first_pc", first_pop, 32'h20);

    // Randomized traffic with occasional redirects and one mid-run reset.
    for (int i = 0; i < 800; i++) begin
      rdy = $urandom_range(0, 9) < 7;
      rd  = $urandom_range(0, 29) == 0;
      case ($urandom_range(0, 3))
        0:       rpc = $urandom_range(0, 32'h3FF);
        1:       rpc = $urandom;
        2:       rpc = 32'hFFFF_FFF0 | $urandom_range(0, 15);
        default: rpc = 32'h3E0 + $urandom_range(0, 31);
      endcase
      if (i == 400) step(0, rdy, 0, 0);
      else          step(1, rdy, rd, rpc);
    end

    // Sequential fetch across the top of instruction memory.
    saw_wrap = 0; saw_pc400 = 0;
    step(1, 1, 1, 32'h3F0);
    for (int i = 0; i < 12; i++) step(1, 1, 0, 0);
`ifdef FETCH_BOUNDS_CHECK_EN
    chk("halt_fault", fetch_fault_o, 1);
    chk("halt_last_pc", last_pop_pc, 32'h3FC);
    chk("halt_no_req", imem_req_o, 0);
    step(1, 1, 1, 32'h0);
    for (int i = 0; i < 6; i++) step(1, 1, 0, 0);
    chk("halt_clear", fetch_fault_o, 0);
    chk("halt_resume_pc", first_pop, 32'h0);
`else
    chk("wrap_addr", saw_wrap, 1);
    chk("wrap_pc400", saw_pc400, 1);
    chk("wrap_fault", fetch_fault_o, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
